// File: rtl/mult_pkg.sv
// Package for mult_tree_pipe: prefix-cell helpers, Baugh-Wooley constant, stage-valid type.
// Signed support is selected by defining MULT_SIGNED_EN (see mult_tree_pipe.sv).
package mult_pkg;

  // One valid bit per pipeline stage: [0]=operand regs, [1]=CSA rows, [2]=product
  typedef logic [2:0] stage_vld_t;

  // Grey cell: group generate only (span already reaches bit 0)
  function automatic logic pfx_g(input logic gik, input logic pik, input logic gkj);
    return gik | (pik & gkj);
  endfunction

  // Black cell: combined {generate, propagate} of two adjacent spans
  function automatic logic [1:0] pfx_gp(input logic gik, input logic pik,
                                        input logic gkj, input logic pkj);
    return {gik | (pik & gkj), pik & pkj};
  endfunction

  // Baugh-Wooley correction: a 1 in columns w and 2w-1 (w up to 32)
  function automatic logic [63:0] bw_const(input int w);
    logic [63:0] c;
    c = '0;
    c[w] = 1'b1;
    c[2*w-1] = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/prefix_adder_2w.sv
// Combinational Kogge-Stone adder, s = a + b mod 2^N. The carry-out is never
// formed: the tree only spans bits 0..N-2, which is all the sum bits need.
module prefix_adder_2w
  import mult_pkg::*;
#(
  parameter int N = 16
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] s
);

  localparam int LVLS = $clog2(N);

  logic [N-1:0]            p0;
  logic [LVLS:0][N-2:0]    g;
  logic [LVLS:0][N-2:0]    p;

  assign p0   = a ^ b;
  assign g[0] = a[N-2:0] & b[N-2:0];
  assign p[0] = p0[N-2:0];

  // Level l combines spans at distance 2^l; spans already anchored at bit 0 use grey cells
  for (genvar l = 0; l < LVLS; l++) begin : g_lvl
    localparam int D = 1 << l;
    for (genvar i = 0; i < N-1; i++) begin : g_bit
      if (i < D) begin : g_pass
        assign g[l+1][i] = g[l][i];
        assign p[l+1][i] = p[l][i];
      end else if (i < 2*D) begin : g_grey
        assign g[l+1][i] = pfx_g(g[l][i], p[l][i], g[l][i-D]);
        assign p[l+1][i] = p[l][i];
      end else begin : g_black
        assign {g[l+1][i], p[l+1][i]} = pfx_gp(g[l][i], p[l][i], g[l][i-D], p[l][i-D]);
      end
    end
  end

  // Carry into bit i is the group generate of bits i-1..0
  assign s = p0 ^ {g[LVLS], 1'b0};

endmodule

// File: rtl/mult_tree_pipe.sv
// Pipelined W x W -> 2W multiplier: AND-array partial products, full-adder
// carry-save reduction to two rows, Kogge-Stone final add. Three register
// stages with valid/ready and full backpressure.
// Define MULT_SIGNED_EN for two's-complement operands (Baugh-Wooley);
// the default build is unsigned. Ports are identical in both builds.
module mult_tree_pipe
  import mult_pkg::*;
#(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   y,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] o
);

  localparam int N = 2*W;
`ifdef MULT_SIGNED_EN
  localparam logic [63:0]  BW_FULL  = bw_const(W);
  localparam logic [N-1:0] BW_CONST = BW_FULL[N-1:0];
  localparam int           NR       = W + 1;  // partial products + constant row
`else
  localparam int           NR       = W;
`endif

  stage_vld_t                vld;
  logic [2:0]                free;
  logic [W-1:0]              xr, yr;
  logic [N-1:0]              ra, rb, sum;
  logic [NR-1:0][N-1:0]      rows;
  logic [NR-2:0][N-1:0]      s_lvl, c_lvl;

  // A stage may load when it is empty or its content leaves this cycle
  assign free[2]   = !vld[2] | out_ready;
  assign free[1]   = !vld[1] | free[2];
  assign free[0]   = !vld[0] | free[1];
  assign in_ready  = free[0];
  assign out_valid = vld[2];

  // Partial products, each row pre-shifted to its column weight
  always_comb begin
    rows = '0;
    for (int i = 0; i < W; i++) begin
      for (int j = 0; j < W; j++) begin
`ifdef MULT_SIGNED_EN
        // Terms mixing exactly one sign bit carry negative weight: invert them
        rows[i][i+j] = (xr[j] & yr[i]) ^ ((i == W-1) != (j == W-1));
`else
        rows[i][i+j] = xr[j] & yr[i];
`endif
      end
    end
`ifdef MULT_SIGNED_EN
    rows[W] = BW_CONST;
`endif
  end

  // Carry-save reduction: each level folds one more row with a rank of full adders.
  // The carry leaving column N-1 is dropped; the result is taken mod 2^N anyway.
  assign s_lvl[0] = rows[0];
  assign c_lvl[0] = rows[1];
  for (genvar k = 1; k < NR-1; k++) begin : g_csa
    assign s_lvl[k] = s_lvl[k-1] ^ c_lvl[k-1] ^ rows[k+1];
    assign c_lvl[k] = {(s_lvl[k-1][N-2:0] & c_lvl[k-1][N-2:0]) |
                       (s_lvl[k-1][N-2:0] & rows[k+1][N-2:0])  |
                       (c_lvl[k-1][N-2:0] & rows[k+1][N-2:0]), 1'b0};
  end

  prefix_adder_2w #(.N(N)) u_add (
    .a (ra),
    .b (rb),
    .s (sum)
  );

  // Valid shift register; a stalled stage keeps its bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
    end else begin
      if (free[0]) vld[0] <= in_valid;
      if (free[1]) vld[1] <= vld[0];
      if (free[2]) vld[2] <= vld[1];
    end
  end

  // Data registers load only with valid content, so idle X inputs never reach o
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xr <= '0;
      yr <= '0;
      ra <= '0;
      rb <= '0;
      o  <= '0;
    end else begin
      if (free[0] && in_valid) begin
        xr <= x;
        yr <= y;
      end
      if (free[1] && vld[0]) begin
        ra <= s_lvl[NR-2];
        rb <= c_lvl[NR-2];
      end
      if (free[2] && vld[1]) o <= sum;
    end
  end

endmodule

// File: tb/tb_mult_tree_pipe.sv
// Bench for mult_tree_pipe: W=4, 8 and 16 instances run in lockstep on shared
// handshakes; a scoreboard checks every output against a bench-side model.
module tb_mult_tree_pipe;

  logic        clk, rst_n, in_valid, out_ready;
  logic        in_ready, in_ready4, in_ready16;
  logic        out_valid, out_valid4, out_valid16;
  logic [3:0]  x4, y4;
  logic [7:0]  x8, y8;
  logic [15:0] x16, y16;
  logic [7:0]  o4;
  logic [15:0] o8;
  logic [31:0] o16;

  int n_cmp = 0;
  int n_bad = 0;
  logic acc = 1'b0;

  typedef struct {
    logic [7:0]  e4;
    logic [15:0] e8;
    logic [31:0] e16;
  } exp_t;
  exp_t sb[$];
  exp_t ent;

  mult_tree_pipe #(.W(4)) u_w4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .x(x4), .y(y4), .out_valid(out_valid4), .out_ready(out_ready), .o(o4));
  mult_tree_pipe #(.W(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x8), .y(y8), .out_valid(out_valid), .out_ready(out_ready), .o(o8));
  mult_tree_pipe #(.W(16)) u_w16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready16),
    .x(x16), .y(y16), .out_valid(out_valid16), .out_ready(out_ready), .o(o16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference product of w-bit operands, mod 2^(2w)
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input int w);
    logic [63:0] ea, eb;
    ea = 64'(a);
    eb = 64'(b);
`ifdef MULT_SIGNED_EN
    if (a[w-1]) ea = ea | (~64'h0 << w);
    if (b[w-1]) eb = eb | (~64'h0 << w);
`endif
    return (ea * eb) & ((64'h1 << (2*w)) - 64'h1);
  endfunction

  // Scoreboard: sample handshakes mid-cycle, away from the active edge
  always @(negedge clk) begin
    logic [63:0] m4, m8, m16;
    acc = rst_n && in_valid && in_ready;
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (acc) begin
        m4 = model(32'(x4), 32'(y4), 4);
        m8 = model(32'(x8), 32'(y8), 8);
        m16 = model(32'(x16), 32'(y16), 16);
        ent.e4 = m4[7:0];
        ent.e8 = m8[15:0];
        ent.e16 = m16[31:0];
        sb.push_back(ent);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("spurious_out", 1, 0);
        end else begin
          ent = sb.pop_front();
          chk("o8", o8, ent.e8);
          chk("o4", {out_valid4, o4}, {1'b1, ent.e4});
          chk("o16", {out_valid16, o16}, {1'b1, ent.e16});
          chk("rdy_lockstep", {in_ready4, in_ready16}, {in_ready, in_ready});
        end
      end
    end
  end

  task automatic set_ops(input logic [7:0] a, input logic [7:0] b);
    x8 = a;        y8 = b;
    x4 = a[3:0];   y4 = b[3:0];
    x16 = {b, a};  y16 = {a, ~b};
  endtask

  task automatic idle_ops();
    x8 = 'x; y8 = 'x; x4 = 'x; y4 = 'x; x16 = 'x; y16 = 'x;
  endtask

  // Present one pair and hold it until accepted (bounded)
  task automatic send(input logic [7:0] a, input logic [7:0] b);
    int t;
    t = 0;
    set_ops(a, b);
    in_valid = 1'b1;
    do begin
      @(posedge clk); #1;
      t++;
    end while (!acc && t < 200);
    if (!acc) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
    idle_ops();
  endtask

  task automatic drain();
    int t;
    t = 0;
    out_ready = 1'b1;
    while ((sb.size() != 0 || out_valid) && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain_empty", 64'(sb.size()), 0);
  endtask

  // Single item into an empty pipe: out_valid exactly 3 edges after acceptance
  task automatic lat(input string tg, input logic [7:0] a, input logic [7:0] b, input logic [15:0] ev);
    out_ready = 1'b1;
    send(a, b);
    @(negedge clk); chk({tg, "_c1"}, out_valid, 0);
    @(negedge clk); chk({tg, "_c2"}, out_valid, 0);
    @(negedge clk); chk({tg, "_c3"}, out_valid, 1); chk({tg, "_o"}, o8, ev);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [15:0] hold;
    int n, cyc;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    idle_ops();
    #1;
    chk("rst_ov", {out_valid4, out_valid, out_valid16}, 0);
    chk("rst_o", {o4, o8, o16}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk); chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Directed products with hand-computed W=8 results
`ifdef MULT_SIGNED_EN
    lat("s_ffff", 8'hFF, 8'hFF, 16'h0001);
    lat("s_8080", 8'h80, 8'h80, 16'h4000);
    lat("s_ff01", 8'hFF, 8'h01, 16'hFFFF);
    lat("s_7f80", 8'h7F, 8'h80, 16'hC080);
`else
    lat("u_ffff", 8'hFF, 8'hFF, 16'hFE01);
    lat("u_8080", 8'h80, 8'h80, 16'h4000);
    lat("u_ff01", 8'hFF, 8'h01, 16'h00FF);
    lat("u_7f80", 8'h7F, 8'h80, 16'h3F80);
`endif
    drain();

    // Back-to-back stream: accepted every cycle
    out_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      set_ops(8'($urandom), 8'($urandom));
      in_valid = 1'b1;
      @(posedge clk); #1;
      chk("b2b_acc", acc, 1);
    end
    in_valid = 1'b0;
    idle_ops();
    drain();

    // Fill with out_ready=0, stall, then release
    out_ready = 1'b0;
    send(8'h11, 8'h22);
    send(8'h33, 8'h44);
    send(8'h55, 8'h66);
    set_ops(8'h77, 8'h88);
    in_valid = 1'b1;
    @(negedge clk);
    chk("full_in_ready", in_ready, 0);
    chk("full_ov", out_valid, 1);
    hold = o8;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_o", o8, hold);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    #1 chk("release_in_ready", in_ready, 1);
    @(negedge clk); chk("release_ov", out_valid, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    idle_ops();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("no_gap_ov", out_valid, 1);
    end
    @(posedge clk); #1;
    drain();

    // Reset with two items in flight, one already at the output
    out_ready = 1'b0;
    send(8'hA5, 8'h5A);
    send(8'hC3, 8'h3C);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("pre_rst_ov", out_valid, 1);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_ov", {out_valid4, out_valid, out_valid16}, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); chk("post_rst_quiet", {out_valid4, out_valid, out_valid16}, 0);
    end
    @(posedge clk); #1;
`ifdef MULT_SIGNED_EN
    lat("rst_next", 8'h12, 8'h34, 16'h03A8);
`else
    lat("rst_next", 8'h12, 8'h34, 16'h03A8);
`endif
    drain();

    // Random valid (70%) and ready (50%) traffic
    n = 0;
    cyc = 0;
    while (n < 10000 && cyc < 60000) begin
      @(posedge clk); #1;
      cyc++;
      if (in_valid && acc) begin
        n++;
        in_valid = 1'b0;
        idle_ops();
      end
      out_ready = ($urandom_range(1, 0) == 1);
      if (!in_valid && n < 10000 && $urandom_range(99, 0) < 70) begin
        set_ops(8'($urandom), 8'($urandom));
        in_valid = 1'b1;
      end
    end
    in_valid = 1'b0;
    idle_ops();
    chk("rand_count", 64'(n), 10000);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
